l2_shared_port: RTL and testbench



---
 rtl/l2_shared_port.sv | 151 +++++++++++++++
 tb/tb_l2_shared_port.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_shared_port.sv
// Shared 1024-word L2 store with a two-core round-robin arbiter.
// It stalls the losing L1 and broadcasts the winner's request to the other L1 as a snoop.
module l2_shared_port #(
  parameter int n     = 32,
  parameter int depth = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c0_read_request,
  input  logic         c1_read_request,
  input  logic         c0_write_request,
  input  logic         c1_write_request,
  input  logic [9:0]   c0_word_address,
  input  logic [9:0]   c1_word_address,
  input  logic [n-1:0] c0_write_word,
  input  logic [n-1:0] c1_write_word,
  output logic [n-1:0] c0_read_word,
  output logic [n-1:0] c1_read_word,
  output logic         c0_busy,
  output logic         c1_busy,
  output logic         c0_others_read_request,
  output logic         c0_others_write_request,
  output logic [3:0]   c0_others_block_tag,
  output logic [3:0]   c0_others_block_index,
  output logic         c1_others_read_request,
  output logic         c1_others_write_request,
  output logic [3:0]   c1_others_block_tag,
  output logic [3:0]   c1_others_block_index,
  output logic [31:0]  L2_statistics
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C0   = 2'd1,
    OWN_C1   = 2'd2
  } owner_t;

  owner_t owner_q;
  owner_t last_q;
  owner_t eff;

  logic req0;
  logic req1;
  logic grant0;
  logic grant1;

  logic [7:0] c0_grant_count;
  logic [7:0] c1_grant_count;
  logic [7:0] c0_stall_count;
  logic [7:0] c1_stall_count;

  logic [n-1:0] mem [0:depth-1];

  // The current owner keeps the grant until it drops its request; ties go to
  // the core that was not served last.
  always_comb begin
    req0 = c0_read_request | c0_write_request;
    req1 = c1_read_request | c1_write_request;
    eff  = OWN_NONE;
    if (owner_q == OWN_C0 && req0) begin
      eff = OWN_C0;
    end else if (owner_q == OWN_C1 && req1) begin
      eff = OWN_C1;
    end else if (req0 && req1) begin
      eff = (last_q == OWN_C0) ? OWN_C1 : OWN_C0;
    end else if (req0) begin
      eff = OWN_C0;
    end else if (req1) begin
      eff = OWN_C1;
    end
  end

  assign grant0 = (eff == OWN_C0);
  assign grant1 = (eff == OWN_C1);

  // An idle core is never stalled, so it can watch the snoop freely.
  assign c0_busy = req0 & ~grant0;
  assign c1_busy = req1 & ~grant1;

  assign c0_others_read_request  = grant1 & c1_read_request;
  assign c0_others_write_request = grant1 & c1_write_request;
  assign c0_others_block_tag     = grant1 ? c1_word_address[9:6] : 4'h0;
  assign c0_others_block_index   = grant1 ? c1_word_address[5:2] : 4'h0;

  assign c1_others_read_request  = grant0 & c0_read_request;
  assign c1_others_write_request = grant0 & c0_write_request;
  assign c1_others_block_tag     = grant0 ? c0_word_address[9:6] : 4'h0;
  assign c1_others_block_index   = grant0 ? c0_word_address[5:2] : 4'h0;

  assign L2_statistics = {c0_grant_count, c1_grant_count, c0_stall_count, c1_stall_count};

  // last_q starts at C1 so core 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      last_q  <= OWN_C1;
    end else begin
      owner_q <= eff;
      if (eff != OWN_NONE) begin
        last_q <= eff;
      end
    end
  end

  // Storage is not reset; only the owner's write reaches it.
  always_ff @(posedge clk) begin
    if (grant0 && c0_write_request) begin
      mem[c0_word_address] <= c0_write_word;
    end else if (grant1 && c1_write_request) begin
      mem[c1_word_address] <= c1_write_word;
    end
  end

  // Read data is sampled before the same-edge write lands, returning old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_read_word <= '0;
      c1_read_word <= '0;
    end else begin
      if (grant0 && c0_read_request) begin
        c0_read_word <= mem[c0_word_address];
      end
      if (grant1 && c1_read_request) begin
        c1_read_word <= mem[c1_word_address];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c0_grant_count <= 8'd0;
      c1_grant_count <= 8'd0;
      c0_stall_count <= 8'd0;
      c1_stall_count <= 8'd0;
    end else begin
      if (grant0 && owner_q != OWN_C0) begin
        c0_grant_count <= c0_grant_count + 8'd1;
      end
      if (grant1 && owner_q != OWN_C1) begin
        c1_grant_count <= c1_grant_count + 8'd1;
      end
      if (c0_busy) begin
        c0_stall_count <= c0_stall_count + 8'd1;
      end
      if (c1_busy) begin
        c1_stall_count <= c1_stall_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_l2_shared_port.sv
// Directed testbench for l2_shared_port: arbitration, snoop, memory and statistics.
module tb_l2_shared_port;

  logic        clk;
  logic        reset;
  logic        c0_read_request;
  logic        c1_read_request;
  logic        c0_write_request;
  logic        c1_write_request;
  logic [9:0]  c0_word_address;
  logic [9:0]  c1_word_address;
  logic [31:0] c0_write_word;
  logic [31:0] c1_write_word;
  logic [31:0] c0_read_word;
  logic [31:0] c1_read_word;
  logic        c0_busy;
  logic        c1_busy;
  logic        c0_others_read_request;
  logic        c0_others_write_request;
  logic [3:0]  c0_others_block_tag;
  logic [3:0]  c0_others_block_index;
  logic        c1_others_read_request;
  logic        c1_others_write_request;
  logic [3:0]  c1_others_block_tag;
  logic [3:0]  c1_others_block_index;
  logic [31:0] L2_statistics;

  int check_count = 0;
  int pass_count  = 0;

  l2_shared_port #(.n(32), .depth(1024)) dut (
    .clk(clk),
    .reset(reset),
    .c0_read_request(c0_read_request),
    .c1_read_request(c1_read_request),
    .c0_write_request(c0_write_request),
    .c1_write_request(c1_write_request),
    .c0_word_address(c0_word_address),
    .c1_word_address(c1_word_address),
    .c0_write_word(c0_write_word),
    .c1_write_word(c1_write_word),
    .c0_read_word(c0_read_word),
    .c1_read_word(c1_read_word),
    .c0_busy(c0_busy),
    .c1_busy(c1_busy),
    .c0_others_read_request(c0_others_read_request),
    .c0_others_write_request(c0_others_write_request),
    .c0_others_block_tag(c0_others_block_tag),
    .c0_others_block_index(c0_others_block_index),
    .c1_others_read_request(c1_others_read_request),
    .c1_others_write_request(c1_others_write_request),
    .c1_others_block_tag(c1_others_block_tag),
    .c1_others_block_index(c1_others_block_index),
    .L2_statistics(L2_statistics)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c0_read_request  = 1'b0;
    c1_read_request  = 1'b0;
    c0_write_request = 1'b0;
    c1_write_request = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    c0_word_address = 10'h0;
    c1_word_address = 10'h0;
    c0_write_word   = 32'h0;
    c1_write_word   = 32'h0;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    check_count++;
    if (c0_read_word !== 32'h0) $display("[TB] FAIL reset_c0_read_word: got %h expected %h", c0_read_word, 32'h0);
    else pass_count++;
    check_count++;
    if (c1_read_word !== 32'h0) $display("[TB] FAIL reset_c1_read_word: got %h expected %h", c1_read_word, 32'h0);
    else pass_count++;
    check_count++;
    if (L2_statistics !== 32'h0) $display("[TB] FAIL reset_stats: got %h expected %h", L2_statistics, 32'h0);
    else pass_count++;
    check_count++;
    if ({c0_busy, c1_busy, c0_others_read_request, c1_others_write_request} !== 4'b0)
      $display("[TB] FAIL reset_busy_snoop: got %b expected %b",
               {c0_busy, c1_busy, c0_others_read_request, c1_others_write_request}, 4'b0);
    else pass_count++;
  endtask

  task automatic test_write_read();
    c0_write_request = 1'b1;
    c0_word_address  = 10'h155;
    c0_write_word    = 32'hDEADBEEF;
    #1;
    check_count++;
    if (c0_busy !== 1'b0) $display("[TB] FAIL wr_c0_busy: got %b expected %b", c0_busy, 1'b0);
    else pass_count++;
    check_count++;
    if ({c1_others_write_request, c1_others_block_tag, c1_others_block_index} !== 9'b1_0101_0101)
      $display("[TB] FAIL wr_c1_snoop: got %b expected %b",
               {c1_others_write_request, c1_others_block_tag, c1_others_block_index}, 9'b1_0101_0101);
    else pass_count++;
    step();
    c0_write_request = 1'b0;
    c0_read_request  = 1'b1;
    #1;
    check_count++;
    if (c0_busy !== 1'b0) $display("[TB] FAIL rd_c0_busy: got %b expected %b", c0_busy, 1'b0);
    else pass_count++;
    step();
    idle_inputs();
    check_count++;
    if (c0_read_word !== 32'hDEADBEEF) $display("[TB] FAIL rd_c0_data: got %h expected %h", c0_read_word, 32'hDEADBEEF);
    else pass_count++;
    step();
    check_count++;
    if (c0_read_word !== 32'hDEADBEEF) $display("[TB] FAIL rd_c0_hold: got %h expected %h", c0_read_word, 32'hDEADBEEF);
    else pass_count++;
    check_count++;
    if (L2_statistics !== 32'h01000000) $display("[TB] FAIL wr_rd_stats: got %h expected %h", L2_statistics, 32'h01000000);
    else pass_count++;
  endtask

  task automatic test_contention();
    do_reset();
    c0_read_request = 1'b1;
    c1_read_request = 1'b1;
    c0_word_address = 10'h155;
    c1_word_address = 10'h155;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_count++;
      if ({c0_busy, c1_busy} !== 2'b01) $display("[TB] FAIL cont_busy_%0d: got %b expected %b", i, {c0_busy, c1_busy}, 2'b01);
      else pass_count++;
      check_count++;
      if ({c1_others_read_request, c0_others_read_request} !== 2'b10)
        $display("[TB] FAIL cont_snoop_%0d: got %b expected %b", i, {c1_others_read_request, c0_others_read_request}, 2'b10);
      else pass_count++;
      step();
    end
    c0_read_request = 1'b0;
    #1;
    check_count++;
    if ({c0_busy, c1_busy, c0_others_read_request} !== 3'b001)
      $display("[TB] FAIL handoff: got %b expected %b", {c0_busy, c1_busy, c0_others_read_request}, 3'b001);
    else pass_count++;
    step();
    idle_inputs();
    check_count++;
    if (c1_read_word !== 32'hDEADBEEF) $display("[TB] FAIL cont_c1_data: got %h expected %h", c1_read_word, 32'hDEADBEEF);
    else pass_count++;
    check_count++;
    if (L2_statistics !== 32'h01010003) $display("[TB] FAIL cont_stats: got %h expected %h", L2_statistics, 32'h01010003);
    else pass_count++;
  endtask

  task automatic test_snoop();
    c1_write_request = 1'b1;
    c1_word_address  = 10'h2C7;
    c1_write_word    = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_count++;
      if ({c0_others_write_request, c0_others_read_request, c0_others_block_tag, c0_others_block_index} !== 10'b10_1011_0001)
        $display("[TB] FAIL snoop_cycle_%0d: got %b expected %b", i,
                 {c0_others_write_request, c0_others_read_request, c0_others_block_tag, c0_others_block_index}, 10'b10_1011_0001);
      else pass_count++;
      step();
    end
    c1_write_request = 1'b0;
    #1;
    check_count++;
    if ({c0_others_write_request, c0_others_block_tag, c0_others_block_index} !== 9'b0)
      $display("[TB] FAIL snoop_after: got %b expected %b",
               {c0_others_write_request, c0_others_block_tag, c0_others_block_index}, 9'b0);
    else pass_count++;
    c0_read_request = 1'b1;
    c0_word_address = 10'h2C7;
    step();
    idle_inputs();
    check_count++;
    if (c0_read_word !== 32'h12345678) $display("[TB] FAIL snoop_write_data: got %h expected %h", c0_read_word, 32'h12345678);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    c0_read_request = 1'b1;
    c1_read_request = 1'b1;
    #1;
    check_count++;
    if ({c0_busy, c1_busy} !== 2'b01) $display("[TB] FAIL b2b_round1: got %b expected %b", {c0_busy, c1_busy}, 2'b01);
    else pass_count++;
    step();
    c0_read_request = 1'b0;
    #1;
    check_count++;
    if ({c0_busy, c1_busy, c0_others_read_request} !== 3'b001)
      $display("[TB] FAIL b2b_round2: got %b expected %b", {c0_busy, c1_busy, c0_others_read_request}, 3'b001);
    else pass_count++;
    step();
    c0_read_request = 1'b1;
    c1_read_request = 1'b0;
    #1;
    check_count++;
    if ({c0_busy, c1_others_read_request} !== 2'b01)
      $display("[TB] FAIL b2b_round3: got %b expected %b", {c0_busy, c1_others_read_request}, 2'b01);
    else pass_count++;
    step();
    idle_inputs();
    step();
    c0_read_request = 1'b1;
    c1_read_request = 1'b1;
    #1;
    check_count++;
    if ({c0_busy, c1_busy} !== 2'b10) $display("[TB] FAIL b2b_rr_tie: got %b expected %b", {c0_busy, c1_busy}, 2'b10);
    else pass_count++;
    step();
    idle_inputs();
    step();
    check_count++;
    if (L2_statistics !== 32'h02020101) $display("[TB] FAIL b2b_stats: got %h expected %h", L2_statistics, 32'h02020101);
    else pass_count++;
  endtask

  task automatic test_reset_mid();
    c0_write_request = 1'b1;
    c0_word_address  = 10'h0AA;
    c0_write_word    = 32'hCAFEF00D;
    step();
    idle_inputs();
    c1_read_request = 1'b1;
    c1_word_address = 10'h2C7;
    step();
    check_count++;
    if (c1_read_word !== 32'h12345678) $display("[TB] FAIL mid_c1_data: got %h expected %h", c1_read_word, 32'h12345678);
    else pass_count++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_count++;
    if (c1_read_word !== 32'h0) $display("[TB] FAIL mid_c1_read_word: got %h expected %h", c1_read_word, 32'h0);
    else pass_count++;
    check_count++;
    if (L2_statistics !== 32'h0) $display("[TB] FAIL mid_stats: got %h expected %h", L2_statistics, 32'h0);
    else pass_count++;
    c0_read_request = 1'b1;
    c0_word_address = 10'h0AA;
    #1;
    check_count++;
    if ({c0_busy, c1_busy} !== 2'b01) $display("[TB] FAIL mid_owner_cleared: got %b expected %b", {c0_busy, c1_busy}, 2'b01);
    else pass_count++;
    step();
    idle_inputs();
    check_count++;
    if (c0_read_word !== 32'hCAFEF00D) $display("[TB] FAIL mid_mem_kept: got %h expected %h", c0_read_word, 32'hCAFEF00D);
    else pass_count++;
  endtask

  task automatic test_stall_wrap();
    do_reset();
    c0_read_request = 1'b1;
    c1_read_request = 1'b1;
    c0_word_address = 10'h155;
    c1_word_address = 10'h155;
    for (int i = 0; i < 255; i++) step();
    check_count++;
    if (L2_statistics !== 32'h010000FF) $display("[TB] FAIL stall_255: got %h expected %h", L2_statistics, 32'h010000FF);
    else pass_count++;
    step();
    idle_inputs();
    check_count++;
    if (L2_statistics !== 32'h01000000) $display("[TB] FAIL stall_wrap: got %h expected %h", L2_statistics, 32'h01000000);
    else pass_count++;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_contention();
    test_snoop();
    test_back_to_back();
    test_reset_mid();
    test_stall_wrap();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
